// File: rtl/sw_pkg.sv
// Shared Smith-Waterman traceback types: direction codes (also used by t_reg_array)
// and the ring controller state encoding.
package sw_pkg;

    typedef enum logic [1:0] {
        DIR_STOP = 2'b00,
        DIR_DIAG = 2'b01,
        DIR_UP   = 2'b10,
        DIR_LEFT = 2'b11
    } dir_e;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_SEEK,
        S_EMIT,
        S_DONE
    } state_e;

endpackage

// File: rtl/tb_ring_ctrl_if.sv
// Host-side handshake bundle of the traceback ring controller: matrix load,
// traceback request, step stream and status.
interface tb_ring_ctrl_if
    import sw_pkg::*;
#(
    parameter int ROW_W = 4,
    parameter int COL_W = 4
);
    logic             load_start;
    logic             ld_valid;
    logic [1:0]       ld_dir;
    logic             ld_ready;
    logic             tb_start;
    logic [ROW_W-1:0] tb_row;
    logic [COL_W-1:0] tb_col;
    logic             step_valid;
    logic             step_ready;
    dir_e             step_dir;
    logic [ROW_W-1:0] step_row;
    logic [COL_W-1:0] step_col;
    logic             busy;
    logic             loaded;
    logic             done;
    logic             err;

    modport master (
        output load_start, ld_valid, ld_dir, tb_start, tb_row, tb_col, step_ready,
        input  ld_ready, step_valid, step_dir, step_row, step_col, busy, loaded, done, err
    );

    modport slave (
        input  load_start, ld_valid, ld_dir, tb_start, tb_row, tb_col, step_ready,
        output ld_ready, step_valid, step_dir, step_row, step_col, busy, loaded, done, err
    );
endinterface

// File: rtl/t_reg_array.sv
// Circular traceback ring: rotates every cycle; a valid cycle replaces the entry
// wrapping around to the head. t_out is the head entry.
module t_reg_array #(
    parameter int REG_NUM = 256
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       valid,
    input  logic [1:0] t_in,
    output logic [1:0] t_out
);

    logic [2*REG_NUM-1:0] ring_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ring_q <= '0;
        end else begin
            ring_q <= {ring_q[2*REG_NUM-3:0], (valid ? t_in : ring_q[2*REG_NUM-1 -: 2])};
        end
    end

    assign t_out = ring_q[1:0];

endmodule

// File: rtl/tb_ring_ctrl.sv
// Traceback ring controller: loads a ROWSxCOLS direction matrix into t_reg_array,
// then walks the traceback path from a requested cell, one step per cell.
//
//   state  | meaning
//   IDLE   | waiting for load_start / tb_start
//   LOAD   | streaming matrix beats into the ring
//   SEEK   | waiting for the current cell to rotate onto ring_t_out
//   EMIT   | presenting a step, held until step_ready
//   DONE   | one-cycle done pulse
module tb_ring_ctrl
    import sw_pkg::*;
#(
    parameter int REG_NUM = 256,
    parameter int ROWS    = 16,
    parameter int COLS    = 16
) (
    input  logic          clk,
    input  logic          reset,
    tb_ring_ctrl_if.slave bus,
    output logic          ring_valid,
    output logic [1:0]    ring_t_in,
    input  logic [1:0]    ring_t_out
);

    localparam int ROW_W = $clog2(ROWS);
    localparam int COL_W = $clog2(COLS);
    localparam int PH_W  = $clog2(REG_NUM);
    localparam int KW    = PH_W + 1;
    localparam int NCELL = ROWS * COLS;
    localparam int CNT_W = $clog2(NCELL + 1);

    state_e           state_q, state_d;
    logic [PH_W-1:0]  ph_q, ph_d;
    logic [PH_W-1:0]  base_q, base_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [ROW_W-1:0] row_q, row_d;
    logic [COL_W-1:0] col_q, col_d;
    dir_e             dir_q, dir_d;
    logic             loaded_q, loaded_d;
    logic             err_q, err_d;

    logic [KW-1:0]    cell_k;
    logic [KW-1:0]    seek_sum;
    logic [KW-1:0]    seek_wrap;
    logic             seek_hit;

    // Entry k sits on ring_t_out one phase after it was written: ph == base+k+1.
    assign cell_k    = KW'(row_q) * KW'(COLS) + KW'(col_q);
    assign seek_sum  = {1'b0, base_q} + cell_k + KW'(1);
    assign seek_wrap = (seek_sum >= KW'(REG_NUM)) ? seek_sum - KW'(REG_NUM) : seek_sum;
    assign seek_hit  = (ph_q == PH_W'(seek_wrap));

    always_comb begin
        state_d  = state_q;
        ph_d     = (ph_q == PH_W'(REG_NUM - 1)) ? '0 : ph_q + 1'b1;
        base_d   = base_q;
        cnt_d    = cnt_q;
        row_d    = row_q;
        col_d    = col_q;
        dir_d    = dir_q;
        loaded_d = loaded_q;
        err_d    = err_q;

        case (state_q)
            S_IDLE: begin
                if (bus.load_start) begin
                    state_d  = S_LOAD;
                    loaded_d = 1'b0;
                    err_d    = 1'b0;
                    cnt_d    = '0;
                end else if (bus.tb_start) begin
                    if (loaded_q) begin
                        state_d = S_SEEK;
                        row_d   = bus.tb_row;
                        col_d   = bus.tb_col;
                        err_d   = 1'b0;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            S_LOAD: begin
                if (bus.ld_valid) begin
                    if (cnt_q == '0) begin
                        base_d = ph_q;
                    end
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == CNT_W'(NCELL - 1)) begin
                        state_d  = S_IDLE;
                        loaded_d = 1'b1;
                    end
                end else if (cnt_q != '0) begin
                    // A gap after the first beat breaks phase alignment; drop the matrix.
                    state_d  = S_IDLE;
                    loaded_d = 1'b0;
                    err_d    = 1'b1;
                end
            end
            S_SEEK: begin
                if (seek_hit) begin
                    dir_d   = dir_e'(ring_t_out);
                    state_d = S_EMIT;
                end
            end
            S_EMIT: begin
                if (bus.step_ready) begin
                    state_d = S_SEEK;
                    case (dir_q)
                        DIR_STOP: state_d = S_DONE;
                        DIR_DIAG: begin
                            if (row_q == '0 || col_q == '0) begin
                                err_d   = 1'b1;
                                state_d = S_DONE;
                            end else begin
                                row_d = row_q - 1'b1;
                                col_d = col_q - 1'b1;
                            end
                        end
                        DIR_UP: begin
                            if (row_q == '0) begin
                                err_d   = 1'b1;
                                state_d = S_DONE;
                            end else begin
                                row_d = row_q - 1'b1;
                            end
                        end
                        default: begin
                            if (col_q == '0) begin
                                err_d   = 1'b1;
                                state_d = S_DONE;
                            end else begin
                                col_d = col_q - 1'b1;
                            end
                        end
                    endcase
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            ph_q     <= '0;
            base_q   <= '0;
            cnt_q    <= '0;
            row_q    <= '0;
            col_q    <= '0;
            dir_q    <= DIR_STOP;
            loaded_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            ph_q     <= ph_d;
            base_q   <= base_d;
            cnt_q    <= cnt_d;
            row_q    <= row_d;
            col_q    <= col_d;
            dir_q    <= dir_d;
            loaded_q <= loaded_d;
            err_q    <= err_d;
        end
    end

    assign bus.ld_ready   = (state_q == S_LOAD);
    assign ring_valid     = (state_q == S_LOAD) & bus.ld_valid;
    assign ring_t_in      = bus.ld_dir;
    assign bus.step_valid = (state_q == S_EMIT);
    assign bus.step_dir   = dir_q;
    assign bus.step_row   = row_q;
    assign bus.step_col   = col_q;
    assign bus.busy       = (state_q != S_IDLE);
    assign bus.loaded     = loaded_q;
    assign bus.done       = (state_q == S_DONE);
    assign bus.err        = err_q;

endmodule

// File: tb/tb_tb_ring_ctrl.sv
// Bench for tb_ring_ctrl driving a real t_reg_array; expected steps go into a
// scoreboard queue that a monitor drains on every accepted step.
module tb_tb_ring_ctrl;
    import sw_pkg::*;

    localparam int N = 256;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       ring_valid;
    logic [1:0] ring_t_in;
    logic [1:0] ring_t_out;

    tb_ring_ctrl_if #(.ROW_W(4), .COL_W(4)) bus ();

    tb_ring_ctrl #(.REG_NUM(256), .ROWS(16), .COLS(16)) dut (
        .clk        (clk),
        .reset      (reset),
        .bus        (bus),
        .ring_valid (ring_valid),
        .ring_t_in  (ring_t_in),
        .ring_t_out (ring_t_out)
    );

    t_reg_array #(.REG_NUM(256)) u_ring (
        .clk   (clk),
        .rst   (~reset),
        .valid (ring_valid),
        .t_in  (ring_t_in),
        .t_out (ring_t_out)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0] dir;
        logic [3:0] row;
        logic [3:0] col;
    } step_t;

    step_t      exp_q[$];
    step_t      mon_e;
    int         tests = 0;
    int         fails = 0;
    logic [7:0] tb_ph;
    logic [7:0] base_tb;
    logic [7:0] idx;
    logic [1:0] mat [N];
    logic       err_b0, ldy_b0, loaded_b0, rv_b0;
    bit         ok;

    // Reference phase: same reset and wrap as the controller's free-running counter.
    always @(posedge clk or negedge reset) begin
        if (!reset) tb_ph <= 8'd0;
        else        tb_ph <= tb_ph + 8'd1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (reset && bus.step_valid && bus.step_ready) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL step_extra: got dir=%0d row=%0d col=%0d expected no step",
                         bus.step_dir, bus.step_row, bus.step_col);
            end else begin
                mon_e = exp_q.pop_front();
                check("step", {22'd0, bus.step_dir, bus.step_row, bus.step_col}, {22'd0, mon_e});
            end
        end
    end

    task automatic push_step(input logic [1:0] d, input int r, input int c);
        exp_q.push_back({d, 4'(r), 4'(c)});
    endtask

    task automatic clear_mat();
        for (int k = 0; k < N; k++) mat[k] = DIR_STOP;
    endtask

    task automatic load_mat(input int nbeats, input bit with_tb);
        @(posedge clk); #1;
        bus.load_start = 1'b1;
        bus.tb_start   = with_tb;
        bus.tb_row     = 4'd1;
        bus.tb_col     = 4'd1;
        @(posedge clk); #1;
        bus.load_start = 1'b0;
        bus.tb_start   = 1'b0;
        for (int k = 0; k < nbeats; k++) begin
            if (k > 0) begin
                @(posedge clk); #1;
            end
            bus.ld_valid = 1'b1;
            bus.ld_dir   = mat[k];
            if (k == 0) begin
                base_tb = tb_ph;
                #1;
                err_b0    = bus.err;
                ldy_b0    = bus.ld_ready;
                loaded_b0 = bus.loaded;
                rv_b0     = ring_valid;
            end
        end
        @(posedge clk); #1;
        bus.ld_valid = 1'b0;
        bus.ld_dir   = 2'b00;
    endtask

    task automatic run_tb(input int r, input int c);
        @(posedge clk); #1;
        bus.tb_start = 1'b1;
        bus.tb_row   = 4'(r);
        bus.tb_col   = 4'(c);
        @(posedge clk); #1;
        bus.tb_start = 1'b0;
    endtask

    task automatic wait_done(output bit seen);
        seen = 1'b0;
        for (int i = 0; i < 3000 && !seen; i++) begin
            @(negedge clk);
            if (bus.done) seen = 1'b1;
        end
    endtask

    task automatic wait_valid(output bit seen);
        seen = 1'b0;
        for (int i = 0; i < 600 && !seen; i++) begin
            @(negedge clk);
            if (bus.step_valid) seen = 1'b1;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.load_start = 1'b0;
        bus.ld_valid   = 1'b0;
        bus.ld_dir     = 2'b00;
        bus.tb_start   = 1'b0;
        bus.tb_row     = 4'd0;
        bus.tb_col     = 4'd0;
        bus.step_ready = 1'b1;

        repeat (2) @(negedge clk);
        check("reset_outputs", {26'd0, bus.busy, bus.loaded, bus.step_valid, bus.done,
                                bus.err, bus.ld_ready}, 32'd0);
        check("reset_ring", {30'd0, ring_t_out}, 32'd0);
        @(posedge clk); #1;
        reset = 1'b1;

        // 1: full load dir=k%4, check phase mapping for a whole revolution
        for (int k = 0; k < N; k++) mat[k] = 2'(k % 4);
        load_mat(256, 1'b0);
        check("t1_ring_valid_b0", {31'd0, rv_b0}, 32'd1);
        check("t1_ld_ready_b0", {31'd0, ldy_b0}, 32'd1);
        @(negedge clk);
        check("t1_loaded", {31'd0, bus.loaded}, 32'd1);
        check("t1_busy", {31'd0, bus.busy}, 32'd0);
        for (int i = 0; i < N; i++) begin
            idx = tb_ph - base_tb - 8'd1;
            check("t1_ring_map", {30'd0, ring_t_out}, {30'd0, mat[idx]});
            @(negedge clk);
        end

        // 2: LEFT walk along row 5
        clear_mat();
        for (int c = 1; c < 16; c++) mat[5*16+c] = DIR_LEFT;
        load_mat(256, 1'b0);
        @(negedge clk);
        check("t2_loaded", {31'd0, bus.loaded}, 32'd1);
        push_step(DIR_LEFT, 5, 3);
        push_step(DIR_LEFT, 5, 2);
        push_step(DIR_LEFT, 5, 1);
        push_step(DIR_STOP, 5, 0);
        run_tb(5, 3);
        wait_done(ok);
        check("t2_done", {31'd0, ok}, 32'd1);
        check("t2_err", {31'd0, bus.err}, 32'd0);
        check("t2_drained", exp_q.size(), 32'd0);

        // 3: diagonal chain with a long stall on the second step
        clear_mat();
        mat[3*16+3] = DIR_DIAG;
        mat[2*16+2] = DIR_DIAG;
        mat[1*16+1] = DIR_DIAG;
        load_mat(256, 1'b0);
        push_step(DIR_DIAG, 3, 3);
        push_step(DIR_DIAG, 2, 2);
        push_step(DIR_DIAG, 1, 1);
        push_step(DIR_STOP, 0, 0);
        bus.step_ready = 1'b0;
        run_tb(3, 3);
        wait_valid(ok);
        check("t3_valid1", {31'd0, ok}, 32'd1);
        @(posedge clk); #1;
        bus.step_ready = 1'b1;
        @(posedge clk); #1;
        bus.step_ready = 1'b0;
        wait_valid(ok);
        check("t3_valid2", {31'd0, ok}, 32'd1);
        for (int i = 0; i < 300; i++) begin
            check("t3_stall_hold", {21'd0, bus.step_valid, bus.step_dir, bus.step_row, bus.step_col},
                  {21'd0, 1'b1, 2'b01, 4'd2, 4'd2});
            @(negedge clk);
        end
        @(posedge clk); #1;
        bus.step_ready = 1'b1;
        wait_done(ok);
        check("t3_done", {31'd0, ok}, 32'd1);
        check("t3_err", {31'd0, bus.err}, 32'd0);
        check("t3_drained", exp_q.size(), 32'd0);

        // 4: UP out of row 0 -> one step, error, done
        clear_mat();
        mat[4] = DIR_UP;
        load_mat(256, 1'b0);
        push_step(DIR_UP, 0, 4);
        run_tb(0, 4);
        wait_done(ok);
        check("t4_done", {31'd0, ok}, 32'd1);
        check("t4_err", {31'd0, bus.err}, 32'd1);
        repeat (5) @(negedge clk);
        check("t4_no_more_steps", {31'd0, bus.step_valid}, 32'd0);
        check("t4_idle", {31'd0, bus.busy}, 32'd0);
        check("t4_drained", exp_q.size(), 32'd0);

        // 5: ld_valid drops after beat 10
        for (int k = 0; k < N; k++) mat[k] = 2'(k % 4);
        load_mat(11, 1'b0);
        check("t5_err_cleared_by_load", {31'd0, err_b0}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        check("t5_err", {31'd0, bus.err}, 32'd1);
        check("t5_loaded", {31'd0, bus.loaded}, 32'd0);
        check("t5_idle", {31'd0, bus.busy}, 32'd0);
        run_tb(2, 2);
        repeat (3) @(negedge clk);
        check("t5_err_stays", {31'd0, bus.err}, 32'd1);
        check("t5_no_start", {30'd0, bus.busy, bus.step_valid}, 32'd0);
        load_mat(256, 1'b0);
        check("t5_reload_clears_err", {31'd0, err_b0}, 32'd0);
        @(negedge clk);
        check("t5_reloaded", {31'd0, bus.loaded}, 32'd1);

        // 6: load_start wins over tb_start; reset mid-SEEK
        load_mat(256, 1'b1);
        check("t6_load_wins", {31'd0, ldy_b0}, 32'd1);
        check("t6_loaded_cleared", {31'd0, loaded_b0}, 32'd0);
        @(negedge clk);
        check("t6_loaded", {31'd0, bus.loaded}, 32'd1);
        run_tb(7, 9);
        @(negedge clk);
        check("t6_in_seek", {30'd0, bus.busy, bus.step_valid}, 32'd2);
        #1;
        reset = 1'b0;
        #1;
        check("t6_reset_outputs", {25'd0, bus.busy, bus.loaded, bus.step_valid, bus.done,
                                   bus.err, bus.ld_ready, ring_valid}, 32'd0);
        check("t6_reset_step", {24'd0, bus.step_dir, bus.step_row, bus.step_col}, 32'd0);
        check("t6_reset_ring", {30'd0, ring_t_out}, 32'd0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b1;
        @(negedge clk);
        check("t6_loaded_after_reset", {31'd0, bus.loaded}, 32'd0);
        check("t6_idle_after_reset", {31'd0, bus.busy}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
